perm_seq_player: RTL and testbench

- Downstream consumer of the 16-entry random permutation generator.
- Snapshots the 64-bit permutation word, checks that it is a true permutation of 0..15, then streams its entries one per valid/ready handshake, with optional pacing gaps.
- On completion it pulses done and shuffle_req so the upstream generator can advance. With loop_en set, it re-captures the next permutation and replays automatically.

---
 rtl/perm_pkg.sv | 22 ++
 rtl/perm_seq_player_if.sv | 14 +
 rtl/perm_check.sv | 19 +
 rtl/perm_seq_player.sv | 128 ++++++++++++
 tb/tb_perm_seq_player.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perm_pkg.sv
// Shared widths, state encoding and entry extraction for the permutation player.
package perm_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned N_ENTRIES = 16;
  localparam int unsigned SEQ_W     = 64;
  localparam int unsigned GAP_W     = 8;

  localparam logic [SEQ_W-1:0] IDENTITY_SEQ = 64'h0123_4567_89AB_CDEF;
  localparam logic [NIB_W-1:0] LAST_IDX     = NIB_W'(N_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, CHECK, PLAY, GAP, RELOAD} state_t;

  // Entry k sits in the k-th nibble from the top (entry 0 = [63:60]).
  function automatic logic [NIB_W-1:0] entry_of(input logic [SEQ_W-1:0] word,
                                                input logic [NIB_W-1:0] k);
    logic [SEQ_W-1:0] shifted;
    shifted = word >> (NIB_W * (N_ENTRIES - 1 - 32'(k)));
    return shifted[NIB_W-1:0];
  endfunction

endpackage

// File: rtl/perm_seq_player_if.sv
// Streaming output channel of the permutation player (valid/ready plus position tags).
interface perm_seq_player_if;
  import perm_pkg::*;

  logic [NIB_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [NIB_W-1:0] out_index;

  modport master (output out_data, out_valid, out_last, out_index, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_index, output out_ready);

endinterface

// File: rtl/perm_check.sv
// Presence bitmap of the 16 nibbles of a word; valid_c when every value 0..15 appears.
module perm_check
  import perm_pkg::*;
(
  input  logic [SEQ_W-1:0]     word,
  output logic [N_ENTRIES-1:0] bitmap_c,
  output logic                 valid_c
);

  always_comb begin
    bitmap_c = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      bitmap_c[entry_of(word, NIB_W'(k))] = 1'b1;
    end
  end

  assign valid_c = &bitmap_c;

endmodule

// File: rtl/perm_seq_player.sv
// Captures a 16-entry permutation, validates it, and streams it out with optional pacing gaps.
module perm_seq_player
  import perm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic [SEQ_W-1:0]  seq_all,
  perm_seq_player_if.master stream,
  output logic              busy,
  output logic              done,
  output logic              shuffle_req,
  output logic              perm_err
);

  localparam logic [GAP_W-1:0] HOLD = GAP_W'(HOLD_CYCLES);

  state_t               state, state_n;
  logic [NIB_W-1:0]     idx, idx_n;
  logic [SEQ_W-1:0]     snap, snap_n;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_n;
  logic                 err_n;
  logic                 done_n;
  logic                 play_n;
  logic                 perm_ok;
  logic [N_ENTRIES-1:0] unused_bitmap;

  perm_check u_check (
    .word     (snap),
    .bitmap_c (unused_bitmap),
    .valid_c  (perm_ok)
  );

  // Next-state and next-datapath values.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    snap_n    = snap;
    gap_cnt_n = gap_cnt;
    err_n     = perm_err;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          snap_n  = seq_all;
          idx_n   = '0;
          err_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (perm_ok) begin
          state_n = PLAY;
        end else begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      PLAY: begin
        if (stream.out_ready) begin
          if (idx == LAST_IDX) begin
            done_n  = 1'b1;
            state_n = loop_en ? RELOAD : IDLE;
          end else begin
            idx_n = idx + NIB_W'(1);
            if (HOLD != '0) begin
              state_n   = GAP;
              gap_cnt_n = HOLD;
            end
          end
        end
      end
      GAP: begin
        gap_cnt_n = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) state_n = PLAY;
      end
      RELOAD: begin
        snap_n  = seq_all;
        idx_n   = '0;
        state_n = CHECK;
      end
      default: state_n = IDLE;
    endcase
    play_n = (state_n == PLAY);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= IDENTITY_SEQ;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      snap    <= snap_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // Output registers; busy also spans the completion pulse cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      stream.out_index <= '0;
      stream.out_data  <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      shuffle_req      <= 1'b0;
      perm_err         <= 1'b0;
    end else begin
      stream.out_valid <= play_n;
      stream.out_last  <= play_n && (idx_n == LAST_IDX);
      stream.out_index <= play_n ? idx_n : '0;
      stream.out_data  <= play_n ? entry_of(snap_n, idx_n) : '0;
      busy             <= (state_n != IDLE) || done_n;
      done             <= done_n;
      shuffle_req      <= done_n;
      perm_err         <= err_n;
    end
  end

endmodule

// File: tb/tb_perm_seq_player.sv
// Bench for perm_seq_player: protocol-level reference model plus directed literal checks.
module tb_perm_seq_player;

  localparam logic [63:0] IDENT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PACE  = 64'h6891_D0CF_5A73_EB24;
  localparam logic [63:0] LOOP2 = 64'h39C0_1245_678A_BDEF;
  localparam logic [63:0] BAD   = 64'h7777_7777_7777_7777;

  logic        clk = 1'b0;
  logic        rst, start0, start1, loop_en;
  logic [63:0] seq_all;
  logic        busy0, done0, sr0, err0;
  logic        busy1, done1, sr1, err1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  perm_seq_player_if if0 ();
  perm_seq_player_if if1 ();

  perm_seq_player #(.HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .loop_en(loop_en), .seq_all(seq_all),
    .stream(if0), .busy(busy0), .done(done0), .shuffle_req(sr0), .perm_err(err0)
  );

  perm_seq_player #(.HOLD_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .loop_en(loop_en), .seq_all(seq_all),
    .stream(if1), .busy(busy1), .done(done1), .shuffle_req(sr1), .perm_err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: expected stream per instance, expressed in cycle numbers.
  bit         armed = 1'b0;
  bit         playing[2];
  bit         reload_now[2];
  bit         err_exp[2];
  int         pos[2];
  int         next_valid[2];
  int         check_cyc[2];
  int         done_cyc[2];
  int         err_set_cyc[2];
  int         err_clr_cyc[2];
  logic [3:0] ent[2][16];
  int         hold[2] = '{0, 2};

  task automatic model_reset(input int d, input int c);
    playing[d]     = 1'b0;
    reload_now[d]  = 1'b0;
    check_cyc[d]   = -1;
    done_cyc[d]    = -1;
    err_set_cyc[d] = -1;
    err_clr_cyc[d] = c + 1;
  endtask

  task automatic capture(input int d, input int c);
    int seen[16];
    bit ok;
    for (int k = 0; k < 16; k++) seen[k] = 0;
    for (int k = 0; k < 16; k++) begin
      ent[d][k] = 4'(seq_all >> (60 - 4 * k));
      seen[ent[d][k]]++;
    end
    ok = 1'b1;
    for (int k = 0; k < 16; k++) if (seen[k] != 1) ok = 1'b0;
    check_cyc[d] = c + 1;
    if (ok) begin
      playing[d]    = 1'b1;
      pos[d]        = 0;
      next_valid[d] = c + 2;
    end else begin
      err_set_cyc[d] = c + 2;
    end
  endtask

  task automatic model_step(input int d, input logic v, input logic [3:0] data,
                            input logic [3:0] idx, input logic last, input logic bsy,
                            input logic dn, input logic sr, input logic pe,
                            input logic rdy, input logic st);
    int c;
    bit ev;
    bit idle;
    c  = cyc;
    ev = playing[d] && (c >= next_valid[d]);
    if (armed) begin
      if (c == err_set_cyc[d]) err_exp[d] = 1'b1;
      if (c == err_clr_cyc[d]) err_exp[d] = 1'b0;
      chk($sformatf("u%0d.out_valid", d), 64'(v), 64'(ev));
      if (ev) begin
        chk($sformatf("u%0d.out_data", d), 64'(data), 64'(ent[d][pos[d]]));
        chk($sformatf("u%0d.out_index", d), 64'(idx), 64'(pos[d]));
      end
      chk($sformatf("u%0d.out_last", d), 64'(last), 64'(ev && pos[d] == 15));
      chk($sformatf("u%0d.busy", d), 64'(bsy),
          64'(playing[d] || c == check_cyc[d] || c == done_cyc[d]));
      chk($sformatf("u%0d.done", d), 64'(dn), 64'(c == done_cyc[d]));
      chk($sformatf("u%0d.shuffle_req", d), 64'(sr), 64'(c == done_cyc[d]));
      chk($sformatf("u%0d.perm_err", d), 64'(pe), 64'(err_exp[d]));
    end
    if (rst) begin
      model_reset(d, c);
    end else if (armed) begin
      idle = !playing[d] && (c != check_cyc[d]) && !reload_now[d];
      if (reload_now[d]) begin
        reload_now[d] = 1'b0;
        capture(d, c);
      end else if (idle && st) begin
        err_clr_cyc[d] = c + 1;
        err_set_cyc[d] = -1;
        capture(d, c);
      end
      if (ev && rdy) begin
        if (pos[d] == 15) begin
          playing[d]    = 1'b0;
          done_cyc[d]   = c + 1;
          reload_now[d] = loop_en;
        end else begin
          pos[d]++;
          next_valid[d] = c + 1 + hold[d];
        end
      end
    end
  endtask

  // Transfer logs used by the directed checks.
  logic [3:0] rx0[$];
  logic [3:0] rx1[$];
  int         hc0[$];
  int first_v0, last_v0, vcnt0, last_c0, idx3_cnt, done_cnt0, done_first0, done_at0, sr_cnt0, busy_hi0;
  int first_v1, last_v1, vcnt1;

  task automatic clear_logs();
    rx0.delete(); rx1.delete(); hc0.delete();
    first_v0 = -1; last_v0 = -1; vcnt0 = 0; last_c0 = -1; idx3_cnt = 0;
    done_cnt0 = 0; done_first0 = -1; done_at0 = -1; sr_cnt0 = 0; busy_hi0 = -1;
    first_v1 = -1; last_v1 = -1; vcnt1 = 0;
  endtask

  always @(negedge clk) begin
    model_step(0, if0.out_valid, if0.out_data, if0.out_index, if0.out_last, busy0, done0, sr0,
               err0, if0.out_ready, start0);
    model_step(1, if1.out_valid, if1.out_data, if1.out_index, if1.out_last, busy1, done1, sr1,
               err1, if1.out_ready, start1);
    if (armed) begin
      if (if0.out_valid) begin
        if (first_v0 < 0) first_v0 = cyc;
        last_v0 = cyc;
        vcnt0++;
        if (if0.out_index == 4'd3) idx3_cnt++;
        if (if0.out_last) last_c0 = cyc;
        if (if0.out_ready) begin
          rx0.push_back(if0.out_data);
          hc0.push_back(cyc);
        end
      end
      if (done0) begin
        if (done_cnt0 == 0) done_first0 = cyc;
        done_at0 = cyc;
        done_cnt0++;
      end
      if (sr0) sr_cnt0++;
      if (busy0) busy_hi0 = cyc;
      if (if1.out_valid) begin
        if (first_v1 < 0) first_v1 = cyc;
        last_v1 = cyc;
        vcnt1++;
        if (if1.out_ready) rx1.push_back(if1.out_data);
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int s;
  int pace[16] = '{6, 8, 9, 1, 13, 0, 12, 15, 5, 10, 7, 3, 14, 11, 2, 4};

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; loop_en = 1'b0; seq_all = IDENT;
    if0.out_ready = 1'b1; if1.out_ready = 1'b1;
    clear_logs();
    tick(3);
    chk("rst_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_index", 64'(if0.out_index), 64'd0);
    chk("rst_perm_err", 64'(err0), 64'd0);
    rst = 1'b0;
    tick(2);

    // Identity playback, back-to-back.
    clear_logs();
    seq_all = IDENT; start0 = 1'b1; s = cyc;
    tick(1); start0 = 1'b0;
    tick(21);
    chk("ident_count", 64'(rx0.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("ident_val%0d", i), 64'(rx0[i]), 64'(i));
    chk("ident_first_valid", 64'(first_v0), 64'(s + 2));
    chk("ident_last_cycle", 64'(last_c0), 64'(s + 17));
    chk("ident_done_cycle", 64'(done_at0), 64'(s + 18));
    chk("ident_done_count", 64'(done_cnt0), 64'd1);
    chk("ident_shuffle_count", 64'(sr_cnt0), 64'd1);
    chk("ident_busy_last", 64'(busy_hi0), 64'(s + 18));

    // Pacing with two idle cycles between transfers.
    clear_logs();
    seq_all = PACE; start1 = 1'b1; s = cyc;
    tick(1); start1 = 1'b0;
    tick(52);
    chk("pace_count", 64'(rx1.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("pace_val%0d", i), 64'(rx1[i]), 64'(pace[i]));
    chk("pace_first_valid", 64'(first_v1), 64'(s + 2));
    chk("pace_span", 64'(last_v1 - first_v1), 64'd45);
    chk("pace_valid_cycles", 64'(vcnt1), 64'd16);

    // Backpressure on entry 3.
    clear_logs();
    seq_all = PACE; start0 = 1'b1; s = cyc;
    tick(1); start0 = 1'b0;
    tick(4); if0.out_ready = 1'b0;
    tick(5); if0.out_ready = 1'b1;
    tick(20);
    chk("bp_hold_cycles", 64'(idx3_cnt), 64'd6);
    chk("bp_count", 64'(rx0.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk($sformatf("bp_val%0d", i), 64'(rx0[i]), 64'(pace[i]));

    // Invalid word, then recovery.
    clear_logs();
    seq_all = BAD; start0 = 1'b1; s = cyc;
    tick(1); start0 = 1'b0;
    tick(1);
    chk("bad_perm_err", 64'(err0), 64'd1);
    chk("bad_busy", 64'(busy0), 64'd0);
    tick(10);
    chk("bad_valid_count", 64'(vcnt0), 64'd0);
    chk("bad_done_count", 64'(done_cnt0), 64'd0);
    chk("bad_err_sticky", 64'(err0), 64'd1);
    clear_logs();
    seq_all = IDENT; start0 = 1'b1;
    tick(1); start0 = 1'b0;
    chk("recover_err_clear", 64'(err0), 64'd0);
    tick(20);
    chk("recover_count", 64'(rx0.size()), 64'd16);
    chk("recover_last_val", 64'(rx0[15]), 64'd15);
    chk("recover_done_count", 64'(done_cnt0), 64'd1);

    // Loop replay with a fresh word.
    clear_logs();
    seq_all = IDENT; loop_en = 1'b1; start0 = 1'b1; s = cyc;
    tick(1); start0 = 1'b0; seq_all = LOOP2;
    tick(17); loop_en = 1'b0;
    tick(22);
    chk("loop_count", 64'(rx0.size()), 64'd32);
    chk("loop_first_done", 64'(done_first0), 64'(s + 18));
    chk("loop_hs15", 64'(hc0[15]), 64'(s + 17));
    chk("loop_hs16", 64'(hc0[16]), 64'(s + 20));
    chk("loop_val16", 64'(rx0[16]), 64'd3);
    chk("loop_val17", 64'(rx0[17]), 64'd9);
    chk("loop_val18", 64'(rx0[18]), 64'd12);
    chk("loop_done_count", 64'(done_cnt0), 64'd2);
    chk("loop_last_done", 64'(done_at0), 64'(s + 36));

    // Start while busy is ignored; reset mid-playback.
    clear_logs();
    seq_all = PACE; start0 = 1'b1; s = cyc;
    tick(1); start0 = 1'b0;
    tick(3); seq_all = IDENT; start0 = 1'b1;
    tick(1); start0 = 1'b0;
    tick(4);
    chk("rst_mid_index", 64'(if0.out_index), 64'd7);
    rst = 1'b1;
    tick(1); rst = 1'b0;
    chk("rst_mid_valid", 64'(if0.out_valid), 64'd0);
    chk("rst_mid_index0", 64'(if0.out_index), 64'd0);
    chk("rst_mid_data", 64'(if0.out_data), 64'd0);
    chk("rst_mid_busy", 64'(busy0), 64'd0);
    chk("busy_start_val4", 64'(rx0[4]), 64'd13);
    chk("busy_start_val6", 64'(rx0[6]), 64'd12);
    tick(2);
    chk("rst_idle_busy", 64'(busy0), 64'd0);
    clear_logs();
    seq_all = IDENT; start0 = 1'b1;
    tick(1); start0 = 1'b0;
    tick(20);
    chk("post_rst_count", 64'(rx0.size()), 64'd16);
    chk("post_rst_val0", 64'(rx0[0]), 64'd0);
    chk("post_rst_val15", 64'(rx0[15]), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
